// File: rtl/flit_fifo.sv
// Flit FIFO: circular buffer with registered read port, no write-to-read bypass.
// Optional sticky overflow/underflow flag enabled by defining FLIT_FIFO_ERR_EN.
module flit_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [2:0]            flit_id,
    output logic                  empty,
    output logic                  full,
    output logic                  err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_q, valid_d;
    logic                  rd_acc, wr_acc;

    always_comb begin
        empty      = (cnt_q == '0);
        full       = (cnt_q == DEPTH_C);
        rd_acc     = rd_en & ~empty;
        // a read in the same cycle frees a slot, so a full FIFO still accepts
        wr_acc     = wr_en & (~full | rd_acc);
        wr_ptr_d   = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
        data_out_d = rd_acc ? mem_q[rd_ptr_q] : data_out_q;
        valid_d    = rd_acc;
        cnt_d      = cnt_q;
        if (wr_acc && !rd_acc)
            cnt_d = cnt_q + 1'b1;
        else if (rd_acc && !wr_acc)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
        end
    end

    // storage is not reset; pointers alone define which slots are live
    always_ff @(posedge clk) begin
        if (rst && wr_acc)
            mem_q[wr_ptr_q] <= data_in;
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_q;
    assign flit_id   = valid_q ? data_out_q[DATA_WIDTH-1:DATA_WIDTH-3] : 3'b000;

`ifdef FLIT_FIFO_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q | (wr_en & full & ~rd_acc) | (rd_en & empty);
    end

    always_ff @(posedge clk) begin
        if (!rst)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_flit_fifo.sv
// Self-checking bench for flit_fifo: directed scenarios then random traffic
// compared cycle by cycle against a queue-based reference model.
module tb_flit_fifo;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] data_in;
    logic          rd_en;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic [2:0]    flit_id;
    logic          empty;
    logic          full;
    logic          err;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    logic          m_vld;
    logic          m_err;

    flit_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(data_out), .valid_out(valid_out), .flit_id(flit_id),
        .empty(empty), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic err_exp;
`ifdef FLIT_FIFO_ERR_EN
        err_exp = m_err;
`else
        err_exp = 1'b0;
`endif
        chk({tag, ".empty"}, DW'(empty), DW'(q.size() == 0));
        chk({tag, ".full"}, DW'(full), DW'(q.size() == DEPTH));
        chk({tag, ".valid"}, DW'(valid_out), DW'(m_vld));
        chk({tag, ".data"}, data_out, m_dout);
        chk({tag, ".flit_id"}, DW'(flit_id), m_vld ? DW'(m_dout[DW-1:DW-3]) : '0);
        chk({tag, ".err"}, DW'(err), DW'(err_exp));
    endtask

    // one clock: apply inputs, advance the model, compare after the edge
    task automatic step(input string tag, input logic r_n, input logic w,
                        input logic [DW-1:0] d, input logic r);
        int  n;
        bit  rd_ok, wr_ok;
        rst = r_n; wr_en = w; data_in = d; rd_en = r;
        @(posedge clk);
        #1;
        if (!r_n) begin
            q.delete();
            m_dout = '0; m_vld = 1'b0; m_err = 1'b0;
        end else begin
            n     = q.size();
            rd_ok = r && (n > 0);
            wr_ok = w && ((n < DEPTH) || rd_ok);
            m_vld = rd_ok;
            if (rd_ok) m_dout = q.pop_front();
            if (wr_ok) q.push_back(d);
            if ((w && !wr_ok) || (r && n == 0)) m_err = 1'b1;
        end
        check_all(tag);
    endtask

    initial begin
        m_dout = '0; m_vld = 1'b0; m_err = 1'b0;
        rst = 1'b0; wr_en = 1'b0; data_in = '0; rd_en = 1'b0;

        // reset then idle
        step("reset", 1'b0, 1'b0, '0, 1'b0);
        step("idle", 1'b1, 1'b0, '0, 1'b0);

        // packet pass-through
        step("pkt_wh", 1'b1, 1'b1, 32'h2000_0001, 1'b0);
        step("pkt_wp", 1'b1, 1'b1, 32'h4000_0002, 1'b0);
        step("pkt_wt", 1'b1, 1'b1, 32'h8000_0003, 1'b0);
        step("pkt_rh", 1'b1, 1'b0, '0, 1'b1);
        chk("pkt_hdr_lit", data_out, 32'h2000_0001);
        step("pkt_rp", 1'b1, 1'b0, '0, 1'b1);
        chk("pkt_pay_lit", data_out, 32'h4000_0002);
        step("pkt_rt", 1'b1, 1'b0, '0, 1'b1);
        chk("pkt_tail_lit", data_out, 32'h8000_0003);
        chk("pkt_tail_id", DW'(flit_id), DW'(3'b100));
        step("pkt_after", 1'b1, 1'b0, '0, 1'b0);
        chk("pkt_after_id", DW'(flit_id), '0);

        // full boundary, dropped write, wrap
        for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 1'b1, 32'h2000_0010 + i, 1'b0);
        chk("full_lit", DW'(full), 1);
        step("overflow", 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
        for (int i = 0; i < 2; i++) step("wrap_rd2", 1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < 2; i++) step("wrap_wr2", 1'b1, 1'b1, 32'h4000_0020 + i, 1'b0);
        for (int i = 0; i < 4; i++) step("wrap_rd4", 1'b1, 1'b0, '0, 1'b1);
        chk("wrap_last_lit", data_out, 32'h4000_0021);

        // simultaneous read/write at full and at empty
        step("rst2", 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step("sim_fill", 1'b1, 1'b1, 32'h8000_0100 + i, 1'b0);
        step("sim_full", 1'b1, 1'b1, 32'h8000_0199, 1'b1);
        chk("sim_full_oldest", data_out, 32'h8000_0100);
        for (int i = 0; i < DEPTH; i++) step("sim_drain", 1'b1, 1'b0, '0, 1'b1);
        chk("sim_new_last", data_out, 32'h8000_0199);
        step("sim_empty", 1'b1, 1'b1, 32'h2000_0200, 1'b1);
        chk("sim_empty_vld", DW'(valid_out), 0);

        // underflow
        step("udf_drain", 1'b1, 1'b0, '0, 1'b1);
        step("underflow", 1'b1, 1'b0, '0, 1'b1);
        step("udf_wr", 1'b1, 1'b1, 32'h4000_0300, 1'b0);
        step("udf_rd", 1'b1, 1'b0, '0, 1'b1);

        // mid-packet reset with wr_en high
        for (int i = 0; i < 3; i++) step("mid_fill", 1'b1, 1'b1, 32'h2000_0400 + i, 1'b0);
        step("mid_rst", 1'b0, 1'b1, 32'h8000_04FF, 1'b1);
        chk("mid_rst_empty", DW'(empty), 1);
        step("mid_after", 1'b1, 1'b0, '0, 1'b1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic rn;
            rn = ($urandom_range(0, 59) != 0);
            step("rand", rn, ($urandom_range(0, 99) < 55), $urandom(), ($urandom_range(0, 99) < 50));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
